if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 41 ++++
 rtl/if_fetch_pc_reg.sv | 35 +++
 rtl/if_fetch.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch unit.
// Optional feature macro: IF_MISALIGN_EXC_EN (misaligned branch target trap).
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int BYTE_W      = 8;
  localparam int STALL_W     = 6;
  localparam int LANE_W      = 2;
  localparam int STALL_FETCH = 0;

  localparam logic [INST_ADDR_W-1:0] PC_RESET   = '0;
  localparam logic [INST_ADDR_W-1:0] PC_STEP    = INST_ADDR_W'(INST_W / BYTE_W);
  localparam logic [LANE_W-1:0]      LANE_ALIGN = '0;

  typedef enum logic [2:0] {
    ST_FETCH0 = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_FETCH2 = 3'd2,
    ST_FETCH3 = 3'd3,
    ST_DONE   = 3'd4
  } fetch_state_t;

  // Successor of a byte-fetch state once its byte has arrived.
  function automatic fetch_state_t next_lane_state(input fetch_state_t s);
    case (s)
      ST_FETCH0: return ST_FETCH1;
      ST_FETCH1: return ST_FETCH2;
      ST_FETCH2: return ST_FETCH3;
      default:   return ST_DONE;
    endcase
  endfunction

  // Byte lane being fetched; the FETCHk encodings equal k.
  function automatic logic [LANE_W-1:0] lane_of(input fetch_state_t s);
    logic [2:0] raw;
    raw = s;
    return raw[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/if_fetch_pc_reg.sv
// Program counter register with next-PC selection: branch load, sequential
// advance by one instruction word, or hold. Wrap at the top of memory is silent.
module pc_reg
  import if_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   advance,
  input  logic [INST_ADDR_W-1:0] target,
  output logic [INST_ADDR_W-1:0] pc
);

  logic [INST_ADDR_W-1:0] pc_next;

  // Next-PC mux: a branch load outranks a sequential advance.
  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = target;
    end else if (advance) begin
      pc_next = pc + PC_STEP;
    end
  end

  // PC register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc <= PC_RESET;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch over an 8-bit memory port: four byte reads per word,
// little-endian assembly, one outstanding request at most.
// Optional feature macro: IF_MISALIGN_EXC_EN adds output if_misalign.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_FETCH0 | requesting/awaiting byte 0 at pc
// ST_FETCH1 | requesting/awaiting byte 1 at pc+1
// ST_FETCH2 | requesting/awaiting byte 2 at pc+2
// ST_FETCH3 | requesting/awaiting byte 3 at pc+3
// ST_DONE   | word presented to IF/ID; waits for stall[0] to drop
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   branch_flag,
  input  logic [INST_ADDR_W-1:0] branch_target,
  output logic                   mem_req,
  output logic [INST_ADDR_W-1:0] mem_addr,
  input  logic                   mem_rvalid,
  input  logic [BYTE_W-1:0]      mem_rdata,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst,
  output logic                   stallreq_if
`ifdef IF_MISALIGN_EXC_EN
  ,
  output logic                   if_misalign
`endif
);

  fetch_state_t           state;
  fetch_state_t           state_next;
  logic [INST_W-1:0]      word_buf;
  logic                   drop;
  logic [INST_ADDR_W-1:0] pc;
  logic [LANE_W-1:0]      lane;
  logic                   fetching;
  logic                   accept;
  logic                   misalign_target;
  logic                   misalign_hold;
  logic                   pc_advance;
  logic                   unused_stall;

  assign unused_stall = ^stall[STALL_W-1:1];
  assign fetching     = (state != ST_DONE);
  assign lane         = lane_of(state);
  assign accept       = mem_req && mem_rvalid;

`ifdef IF_MISALIGN_EXC_EN
  logic misalign_q;

  assign misalign_target = (branch_target[LANE_W-1:0] != LANE_ALIGN);
  assign misalign_hold   = misalign_q;
  assign if_misalign     = misalign_q;

  // Trap flag: set by a misaligned branch, cleared by the next aligned one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else if (branch_flag) begin
      misalign_q <= misalign_target;
    end
  end
`else
  assign misalign_target = 1'b0;
  assign misalign_hold   = 1'b0;
`endif

  // Sequential step only when the presented word is released downstream.
  assign pc_advance = (state == ST_DONE) && !stall[STALL_FETCH] &&
                      !misalign_hold && !branch_flag;

  pc_reg u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (branch_flag),
    .advance (pc_advance),
    .target  (branch_target),
    .pc      (pc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_FETCH0;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: a branch overrides everything, including a byte
  // arriving in the same cycle.
  always_comb begin
    state_next = state;
    if (branch_flag) begin
      state_next = misalign_target ? ST_DONE : ST_FETCH0;
    end else if (fetching) begin
      if (accept) begin
        state_next = next_lane_state(state);
      end
    end else if (!stall[STALL_FETCH] && !misalign_hold) begin
      state_next = ST_FETCH0;
    end
  end

  // FSM outputs: request bytes while fetching, present the word when done.
  // While a pre-branch response is still in flight the request is held low.
  always_comb begin
    mem_req     = 1'b0;
    mem_addr    = pc;
    stallreq_if = 1'b0;
    if_pc       = '0;
    if_inst     = '0;
    if (fetching) begin
      mem_req     = !drop;
      mem_addr    = pc + INST_ADDR_W'(lane);
      stallreq_if = 1'b1;
    end else begin
      if_pc   = pc;
      if_inst = misalign_hold ? '0 : word_buf;
    end
  end

  // Drop flag: a branch that strands an unanswered request must swallow
  // that request's eventual response instead of taking it as byte 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop <= 1'b0;
    end else if (branch_flag) begin
      drop <= (drop || mem_req) && !mem_rvalid;
    end else if (mem_rvalid) begin
      drop <= 1'b0;
    end
  end

  // Byte assembly, little-endian by lane.
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_buf <= '0;
    end else if (branch_flag) begin
      word_buf <= '0;
    end else if (accept) begin
      word_buf[int'(lane) * BYTE_W +: BYTE_W] <= mem_rdata;
    end
  end

endmodule
